// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants and fetch state encoding
// Purpose: default ADDR_WIDTH / DATA_WIDTH / FIFO_DEPTH values and the
//          IDLE / FETCH / FULL state encoding used by the fetch unit.
// Ports:   none (package).
package ifetch_pkg;

   localparam int IF_ADDR_WIDTH = 12;
   localparam int IF_DATA_WIDTH = 16;
   localparam int IF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch unit bus bundle (PC, instruction memory, decode)
// Purpose: groups the program-counter, instruction-memory and decode-side
//          handshake signals of the fetch unit.
// Signals: pc_count, pc_stall, flush            program-counter side
//          imem_req, imem_addr, imem_rdata      instruction-memory side
//          instr_valid, instr_ready,
//          instr_data, instr_pc                 decode side
//          imem_parity, parity_err              only with IFETCH_PARITY_EN
// Modports: master = fetch unit, slave = surrounding pipeline / memory.
interface instruction_fetch_if
   import ifetch_pkg::*;
#(
   parameter int ADDR_WIDTH = IF_ADDR_WIDTH,
   parameter int DATA_WIDTH = IF_DATA_WIDTH
);

   logic [ADDR_WIDTH-1:0] pc_count;
   logic                  pc_stall;
   logic                  flush;
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_rdata;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_WIDTH-1:0] instr_data;
   logic [ADDR_WIDTH-1:0] instr_pc;

`ifdef IFETCH_PARITY_EN
   logic                  imem_parity;
   logic                  parity_err;

   modport master (
      input  pc_count, flush, imem_rdata, imem_parity, instr_ready,
      output pc_stall, imem_req, imem_addr, instr_valid, instr_data, instr_pc, parity_err
   );

   modport slave (
      output pc_count, flush, imem_rdata, imem_parity, instr_ready,
      input  pc_stall, imem_req, imem_addr, instr_valid, instr_data, instr_pc, parity_err
   );
`else
   modport master (
      input  pc_count, flush, imem_rdata, instr_ready,
      output pc_stall, imem_req, imem_addr, instr_valid, instr_data, instr_pc
   );

   modport slave (
      output pc_count, flush, imem_rdata, instr_ready,
      input  pc_stall, imem_req, imem_addr, instr_valid, instr_data, instr_pc
   );
`endif

endinterface

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous instruction buffer storing {pc, data}
// Purpose: power-of-two deep FIFO; pointers wrap naturally at DEPTH.
// Ports:   clk, reset (sync, active-high), clear (drop all entries),
//          push/wdata, pop/rdata (rdata is zero while empty),
//          full, empty, count (occupancy 0..DEPTH).
module ifetch_fifo #(
   parameter int WIDTH = 28,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // Push when full and pop when empty are dropped.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Zero while empty so the head outputs read 0 after reset/flush.
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch unit with prefetch buffer
// Purpose: issues one-cycle-latency instruction-memory reads at pc_count,
//          buffers the returned words with their address and hands them to
//          decode over a valid/ready handshake; flush drops everything.
// Ports:   clk, reset (sync, active-high), bus (instruction_fetch_if.master).
// Option:  IFETCH_PARITY_EN adds imem_parity input and sticky parity_err.
module instruction_fetch
   import ifetch_pkg::*;
#(
   parameter int ADDR_WIDTH = IF_ADDR_WIDTH,
   parameter int DATA_WIDTH = IF_DATA_WIDTH,
   parameter int FIFO_DEPTH = IF_FIFO_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   instruction_fetch_if.master bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   state_t                           state;
   state_t                           state_next;
   logic                             inflight;
   logic [ADDR_WIDTH-1:0]            req_pc;
   logic                             imem_req;
   logic                             push;
   logic                             pop;
   logic                             fifo_full;
   logic                             fifo_empty;
   logic [CW-1:0]                    fifo_count;
   logic [CW-1:0]                    fifo_next;
   logic [CW-1:0]                    occ;
   logic [CW-1:0]                    occ_next;
   logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_rdata;

   // Occupancy counts the outstanding read so the buffer can never overflow.
   assign occ      = fifo_count + CW'(inflight);
   assign imem_req = !reset && (state == FETCH) && !bus.flush && (occ < DEPTH_C);

   // The response to last cycle's request is on imem_rdata now; a flush or
   // reset in this cycle discards it.
   assign push = inflight && !bus.flush && !reset && !fifo_full;
   assign pop  = bus.instr_ready && !fifo_empty;

   ifetch_fifo #(
      .WIDTH (ADDR_WIDTH + DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (bus.flush),
      .push  (push),
      .wdata ({req_pc, bus.imem_rdata}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         inflight <= 1'b0;
         req_pc   <= '0;
      end else begin
         state    <= state_next;
         inflight <= imem_req;
         if (imem_req) begin
            req_pc <= bus.pc_count;
         end
      end
   end

   // FULL is decided on next-cycle occupancy, so fetching resumes the cycle
   // right after a pop frees a slot.
   always_comb begin
      fifo_next  = fifo_count;
      occ_next   = '0;
      state_next = state;
      if (push && !pop) begin
         fifo_next = fifo_count + 1'b1;
      end else if (!push && pop) begin
         fifo_next = fifo_count - 1'b1;
      end
      occ_next = fifo_next + CW'(imem_req);
      case (state)
         IDLE: state_next = FETCH;
         FETCH: begin
            if (bus.flush) begin
               state_next = FETCH;
            end else if (occ_next >= DEPTH_C) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (bus.flush) begin
               state_next = FETCH;
            end else if (occ_next < DEPTH_C) begin
               state_next = FETCH;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.imem_req    = imem_req;
   assign bus.imem_addr   = bus.pc_count;
   assign bus.pc_stall    = !imem_req;
   assign bus.instr_valid = !fifo_empty;
   assign {bus.instr_pc, bus.instr_data} = fifo_rdata;

`ifdef IFETCH_PARITY_EN
   logic parity_err_q;

   // Even parity: data bits plus parity bit must hold an even number of ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_err_q <= 1'b0;
      end else if (push && (^{bus.imem_rdata, bus.imem_parity})) begin
         parity_err_q <= 1'b1;
      end
   end

   assign bus.parity_err = parity_err_q;
`endif

endmodule
